// File: rtl/mesh_term_tx_fifo.sv
// Terminal-side transmit FIFO feeding one mesh router input port.
// First-word-fall-through head with pending/pop handshake, overflow capture and sticky underflow.
module mesh_term_tx_fifo #(
    parameter int unsigned pckg_sz    = 40,
    parameter int unsigned fifo_depth = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [pckg_sz-1:0]            din,
    output logic                          full,
    output logic [$clog2(fifo_depth):0]   count,
    input  logic                          popin,
    output logic                          pndng,
    output logic [pckg_sz-1:0]            data_out,
    output logic                          overflow,
    output logic [pckg_sz-1:0]            ovf_data,
    output logic                          underflow,
    output logic [31:0]                   sent_cnt
);

    localparam int unsigned PW = $clog2(fifo_depth);
    localparam int unsigned CW = $clog2(fifo_depth) + 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(fifo_depth - 1);
    localparam logic [CW-1:0] DEPTH    = CW'(fifo_depth);

    logic [pckg_sz-1:0] mem_q [fifo_depth];

    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [pckg_sz-1:0] ovf_data_q, ovf_data_d;
    logic               underflow_q, underflow_d;
    logic [31:0]        sent_cnt_q, sent_cnt_d;

    logic not_empty;
    logic do_pop;
    logic do_push;

    assign not_empty = (count_q != '0);
    assign do_pop    = popin & not_empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign do_push   = push & ((count_q < DEPTH) | do_pop);

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        ovf_data_d  = ovf_data_q;
        underflow_d = underflow_q;
        sent_cnt_d  = sent_cnt_q;

        if (do_pop) begin
            rd_ptr_d   = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            sent_cnt_d = sent_cnt_q + 32'd1;
        end

        if (do_push) begin
            wr_ptr_d   = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            overflow_d = 1'b0;
        end else if (push) begin
            overflow_d = 1'b1;
            ovf_data_d = din;
        end

        if (popin && !not_empty) begin
            underflow_d = 1'b1;
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            ovf_data_q  <= '0;
            underflow_q <= 1'b0;
            sent_cnt_q  <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            ovf_data_q  <= ovf_data_d;
            underflow_q <= underflow_d;
            sent_cnt_q  <= sent_cnt_d;
        end
    end

    // Storage is intentionally left uncleared by reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign full      = (count_q == DEPTH);
    assign pndng     = not_empty;
    assign count     = count_q;
    assign data_out  = not_empty ? mem_q[rd_ptr_q] : '0;
    assign overflow  = overflow_q;
    assign ovf_data  = ovf_data_q;
    assign underflow = underflow_q;
    assign sent_cnt  = sent_cnt_q;

endmodule

// File: tb/tb_mesh_term_tx_fifo.sv
// Self-checking bench for mesh_term_tx_fifo: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_mesh_term_tx_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: depth 4
    logic        push_a = 1'b0, popin_a = 1'b0;
    logic [39:0] din_a = '0;
    logic        full_a, pndng_a, ovf_a, unf_a;
    logic [2:0]  count_a;
    logic [39:0] dout_a, ovfd_a;
    logic [31:0] sent_a;

    // Instance B: depth 3 (non power of two)
    logic        push_b = 1'b0, popin_b = 1'b0;
    logic [39:0] din_b = '0;
    logic        full_b, pndng_b, ovf_b, unf_b;
    logic [2:0]  count_b;
    logic [39:0] dout_b, ovfd_b;
    logic [31:0] sent_b;

    mesh_term_tx_fifo #(.pckg_sz(40), .fifo_depth(4)) dut_a (
        .clk(clk), .reset(rst_n), .push(push_a), .din(din_a), .full(full_a),
        .count(count_a), .popin(popin_a), .pndng(pndng_a), .data_out(dout_a),
        .overflow(ovf_a), .ovf_data(ovfd_a), .underflow(unf_a), .sent_cnt(sent_a)
    );

    mesh_term_tx_fifo #(.pckg_sz(40), .fifo_depth(3)) dut_b (
        .clk(clk), .reset(rst_n), .push(push_b), .din(din_b), .full(full_b),
        .count(count_b), .popin(popin_b), .pndng(pndng_b), .data_out(dout_b),
        .overflow(ovf_b), .ovf_data(ovfd_b), .underflow(unf_b), .sent_cnt(sent_b)
    );

    // Reference model state for instance A
    logic [39:0] mq[$];
    bit          m_ovf;
    logic [39:0] m_ovfd;
    bit          m_unf;
    int unsigned m_sent;

    task automatic model_reset();
        mq.delete();
        m_ovf = 0; m_ovfd = '0; m_unf = 0; m_sent = 0;
    endtask

    task automatic model_step(input bit p, input logic [39:0] d, input bit po);
        int  sz;
        bit  room;
        sz   = mq.size();
        room = (sz < 4) || (po && sz > 0);
        if (po) begin
            if (sz > 0) begin
                void'(mq.pop_front());
                m_sent++;
            end else begin
                m_unf = 1;
            end
        end
        if (p) begin
            if (room) begin
                mq.push_back(d);
                m_ovf = 0;
            end else begin
                m_ovf  = 1;
                m_ovfd = d;
            end
        end
    endtask

    task automatic do_reset();
        push_a = 0; popin_a = 0; push_b = 0; popin_b = 0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic cyc_a(input bit p, input logic [39:0] d, input bit po);
        push_a = p; din_a = d; popin_a = po;
        @(posedge clk); #1;
        push_a = 0; popin_a = 0;
    endtask

    task automatic cyc_b(input bit p, input logic [39:0] d, input bit po);
        push_b = p; din_b = d; popin_b = po;
        @(posedge clk); #1;
        push_b = 0; popin_b = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        push_a = 1; din_a = 40'h12_3456_789A;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pndng_a !== 1'b0 || count_a !== 3'd0 || full_a !== 1'b0 || dout_a !== 40'h0) begin
            errors++;
            $display("FAIL reset_state: pndng=%b count=%0d full=%b data=%h, want 0/0/0/0",
                     pndng_a, count_a, full_a, dout_a);
        end
        checks++;
        if (ovf_a !== 1'b0 || unf_a !== 1'b0 || sent_a !== 32'd0 || ovfd_a !== 40'h0) begin
            errors++;
            $display("FAIL reset_flags: ovf=%b unf=%b sent=%0d ovfd=%h, want all 0",
                     ovf_a, unf_a, sent_a, ovfd_a);
        end
        push_a = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_order();
        logic [39:0] exp_head;
        do_reset();
        for (int i = 1; i <= 4; i++) cyc_a(1, 40'(i), 0);
        checks++;
        if (full_a !== 1'b1 || count_a !== 3'd4 || dout_a !== 40'h01) begin
            errors++;
            $display("FAIL order_full: full=%b count=%0d head=%h, want 1/4/01", full_a, count_a, dout_a);
        end
        for (int i = 1; i <= 4; i++) begin
            cyc_a(0, '0, 1);
            exp_head = (i < 4) ? 40'(i + 1) : 40'h0;
            checks++;
            if (dout_a !== exp_head || pndng_a !== (i < 4)) begin
                errors++;
                $display("FAIL order_pop%0d: head=%h pndng=%b, want %h/%b", i, dout_a, pndng_a,
                         exp_head, (i < 4));
            end
        end
        checks++;
        if (sent_a !== 32'd4) begin
            errors++;
            $display("FAIL order_sent: sent=%0d, want 4", sent_a);
        end
    endtask

    task automatic test_overflow();
        logic [39:0] exp_order [4];
        exp_order[0] = 40'h02; exp_order[1] = 40'h03; exp_order[2] = 40'h04; exp_order[3] = 40'hBB;
        do_reset();
        for (int i = 1; i <= 4; i++) cyc_a(1, 40'(i), 0);
        cyc_a(1, 40'hAA, 0);
        checks++;
        if (ovf_a !== 1'b1 || ovfd_a !== 40'hAA || count_a !== 3'd4 || dout_a !== 40'h01) begin
            errors++;
            $display("FAIL ovf_set: ovf=%b ovfd=%h count=%0d head=%h, want 1/AA/4/01",
                     ovf_a, ovfd_a, count_a, dout_a);
        end
        cyc_a(0, '0, 1);
        checks++;
        if (ovf_a !== 1'b1 || count_a !== 3'd3) begin
            errors++;
            $display("FAIL ovf_hold: ovf=%b count=%0d, want 1/3", ovf_a, count_a);
        end
        cyc_a(1, 40'hBB, 0);
        checks++;
        if (ovf_a !== 1'b0 || ovfd_a !== 40'hAA || count_a !== 3'd4) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b ovfd=%h count=%0d, want 0/AA/4", ovf_a, ovfd_a, count_a);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout_a !== exp_order[i]) begin
                errors++;
                $display("FAIL ovf_drain%0d: head=%h, want %h", i, dout_a, exp_order[i]);
            end
            cyc_a(0, '0, 1);
        end
    endtask

    task automatic test_full_simul();
        logic [39:0] exp_order [4];
        exp_order[0] = 40'h02; exp_order[1] = 40'h03; exp_order[2] = 40'h04; exp_order[3] = 40'hCC;
        do_reset();
        for (int i = 1; i <= 4; i++) cyc_a(1, 40'(i), 0);
        cyc_a(1, 40'hCC, 1);
        checks++;
        if (count_a !== 3'd4 || ovf_a !== 1'b0 || full_a !== 1'b1 || sent_a !== 32'd1) begin
            errors++;
            $display("FAIL full_simul: count=%0d ovf=%b full=%b sent=%0d, want 4/0/1/1",
                     count_a, ovf_a, full_a, sent_a);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout_a !== exp_order[i]) begin
                errors++;
                $display("FAIL full_drain%0d: head=%h, want %h", i, dout_a, exp_order[i]);
            end
            cyc_a(0, '0, 1);
        end
    endtask

    task automatic test_empty_simul();
        do_reset();
        cyc_a(1, 40'h55, 1);
        checks++;
        if (count_a !== 3'd1 || dout_a !== 40'h55 || unf_a !== 1'b1 || sent_a !== 32'd0) begin
            errors++;
            $display("FAIL empty_simul: count=%0d head=%h unf=%b sent=%0d, want 1/55/1/0",
                     count_a, dout_a, unf_a, sent_a);
        end
        cyc_a(0, '0, 1);
        cyc_a(0, '0, 0);
        checks++;
        if (count_a !== 3'd0 || unf_a !== 1'b1 || sent_a !== 32'd1 || pndng_a !== 1'b0) begin
            errors++;
            $display("FAIL unf_sticky: count=%0d unf=%b sent=%0d pndng=%b, want 0/1/1/0",
                     count_a, unf_a, sent_a, pndng_a);
        end
    endtask

    task automatic test_wrap_reset();
        int unsigned next_in;
        int unsigned next_out;
        do_reset();
        next_in = 100; next_out = 100;
        cyc_b(1, 40'(next_in), 0); next_in++;
        cyc_b(1, 40'(next_in), 0); next_in++;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (dout_b !== 40'(next_out) || count_b !== 3'd2) begin
                errors++;
                $display("FAIL wrap_%0d: head=%h count=%0d, want %h/2", i, dout_b, count_b,
                         40'(next_out));
            end
            cyc_b(1, 40'(next_in), 1);
            next_in++; next_out++;
        end
        checks++;
        if (sent_b !== 32'd10 || ovf_b !== 1'b0) begin
            errors++;
            $display("FAIL wrap_sent: sent=%0d ovf=%b, want 10/0", sent_b, ovf_b);
        end
        cyc_b(0, '0, 1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (count_b !== 3'd0 || pndng_b !== 1'b0 || dout_b !== 40'h0) begin
            errors++;
            $display("FAIL async_reset: count=%0d pndng=%b head=%h, want 0/0/0", count_b, pndng_b, dout_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cyc_b(1, 40'h77, 0);
        checks++;
        if (dout_b !== 40'h77 || count_b !== 3'd1 || sent_b !== 32'd0) begin
            errors++;
            $display("FAIL post_reset: head=%h count=%0d sent=%0d, want 77/1/0", dout_b, count_b, sent_b);
        end
    endtask

    task automatic test_random();
        bit          p, po;
        logic [39:0] d;
        logic [39:0] exp_head;
        int          bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            p  = ($urandom_range(0, 99) < 60);
            po = ($urandom_range(0, 99) < 45);
            d  = {$urandom(), $urandom()} & 40'hFF_FFFF_FFFF;
            cyc_a(p, d, po);
            model_step(p, d, po);
            exp_head = (mq.size() != 0) ? mq[0] : 40'h0;
            checks++;
            if (int'(count_a) != mq.size() || dout_a !== exp_head || pndng_a !== (mq.size() != 0) ||
                full_a !== (mq.size() == 4) || ovf_a !== m_ovf || ovfd_a !== m_ovfd ||
                unf_a !== m_unf || sent_a !== m_sent) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_%0d: count=%0d head=%h ovf=%b ovfd=%h unf=%b sent=%0d, want %0d/%h/%b/%h/%b/%0d",
                             i, count_a, dout_a, ovf_a, ovfd_a, unf_a, sent_a,
                             mq.size(), exp_head, m_ovf, m_ovfd, m_unf, m_sent);
            end
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_overflow();
        test_full_simul();
        test_empty_simul();
        test_wrap_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
